// File: rtl/stream_uart_pkg.sv
// Shared types and constants for the stream-to-UART transmitter.
package stream_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        EOL
    } uart_state_e;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/stream_uart_tx_if.sv
// Byte stream handshake between a producer (master) and the UART transmitter (slave).
interface stream_uart_tx_if;

    logic [7:0] tdata;
    logic       tlast;
    logic       tvalid;
    logic       tready;

    modport master (
        output tdata,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tlast,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/stream_uart_baud_tick.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the last cycle of each bit.
// A synchronous clear realigns the count so a new start bit gets a full period.
module stream_uart_baud_tick #(
    parameter int unsigned DIV = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Divider counter with wrap on every bit boundary.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign o_tick = i_en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/stream_uart_tx.sv
// Stream byte sink that serialises each accepted byte as 8N1 UART.
// Optional build macro STREAM_UART_EOL_EN: after a byte with tlast set, a CR and an LF
// frame are appended before the block becomes ready again.
module stream_uart_tx
    import stream_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 16000000,
    parameter int unsigned BAUD_RATE   = 57600
) (
    input  logic             i_clk,
    input  logic             i_rst,
    stream_uart_tx_if.slave  s_axis,
    output logic             o_uart_tx
);

    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);

    if (DIV < 2) begin : g_div_check
        $error("stream_uart_tx: DIV must be at least 2");
    end

    uart_state_e state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic        tx_q;
    logic        tready_q;
    logic        handshake;
    logic        tick;

`ifdef STREAM_UART_EOL_EN
    // Number of trailing CR/LF frames still to send.
    logic [1:0]  eol_left_q;
`endif

    assign handshake     = s_axis.tvalid && tready_q;
    assign s_axis.tready = tready_q;
    assign o_uart_tx     = tx_q;

    stream_uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (handshake),
        .i_en    (state_q != IDLE),
        .o_tick  (tick)
    );

    // Frame sequencer; line and ready are registered alongside the state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            tready_q  <= 1'b0;
`ifdef STREAM_UART_EOL_EN
            eol_left_q <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_q     <= 1'b1;
                    tready_q <= 1'b1;
                    if (handshake) begin
                        shift_q  <= s_axis.tdata;
                        tready_q <= 1'b0;
                        tx_q     <= 1'b0;
                        state_q  <= START;
`ifdef STREAM_UART_EOL_EN
                        eol_left_q <= s_axis.tlast ? 2'd2 : 2'd0;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            tx_q      <= shift_q[1];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
`ifdef STREAM_UART_EOL_EN
                        if (eol_left_q != 2'd0) begin
                            // EOL doubles as the start bit of the appended frame.
                            tx_q       <= 1'b0;
                            shift_q    <= (eol_left_q == 2'd2) ? CHAR_CR : CHAR_LF;
                            eol_left_q <= eol_left_q - 2'd1;
                            state_q    <= EOL;
                        end else begin
                            tready_q <= 1'b1;
                            state_q  <= IDLE;
                        end
`else
                        tready_q <= 1'b1;
                        state_q  <= IDLE;
`endif
                    end
                end
`ifdef STREAM_UART_EOL_EN
                EOL: begin
                    if (tick) begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end
`endif
                default: begin
                    tx_q     <= 1'b1;
                    tready_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_uart_tx.sv
// Directed bench for stream_uart_tx at DIV=16 (16 MHz clock, 1 Mbaud).
module tb_stream_uart_tx;

    localparam int unsigned DIV = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        txd;
    int unsigned cyc = 0;
    int unsigned vecs = 0;
    int unsigned errs = 0;

    logic        rx_en = 1'b0;
    logic [7:0]  rx_q[$];

    stream_uart_tx_if axis ();

    stream_uart_tx #(
        .CLK_FREQ_HZ (16000000),
        .BAUD_RATE   (1000000)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .s_axis    (axis),
        .o_uart_tx (txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait until tready is high in the current cycle.
    task automatic wait_ready();
        int unsigned n;
        n = 0;
        while (axis.tready !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        if (axis.tready !== 1'b1) chk("ready_timeout", {31'd0, axis.tready}, 32'd1);
    endtask

    // Single handshake; returns with the bench in cycle N+1.
    task automatic send_byte(input logic [7:0] b, input logic last, output int unsigned hs);
        wait_ready();
        axis.tdata  = b;
        axis.tlast  = last;
        axis.tvalid = 1'b1;
        hs = cyc;
        step();
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
    endtask

    // Cycle-exact frame check starting at N+1; returns in cycle N+161.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic exp;
        int unsigned slot;
        for (int c = 0; c < 10 * DIV; c++) begin
            slot = c / DIV;
            if (slot == 0) exp = 1'b0;
            else if (slot == 9) exp = 1'b1;
            else exp = b[slot - 1];
            chk({tag, "_line"}, {31'd0, txd}, {31'd0, exp});
            chk({tag, "_busy"}, {31'd0, axis.tready}, 32'd0);
            step();
        end
    endtask

    // Line decoder: samples each bit in mid-period after a falling edge.
    initial begin : uart_rx
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #2;
            if (rx_en && txd === 1'b0) begin
                repeat (DIV / 2) @(posedge clk);
                #2;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(posedge clk);
                    #2;
                    b[i] = txd;
                end
                repeat (DIV) @(posedge clk);
                #2;
                chk("rx_stop", {31'd0, txd}, 32'd1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin : stim
        int unsigned hs [3];
        int unsigned h;
        int unsigned hk;
        int unsigned rdy_cyc;
        logic [7:0] seq [3];
        logic [7:0] exp_ok [$];

        axis.tdata  = 8'h00;
        axis.tlast  = 1'b0;
        axis.tvalid = 1'b0;

        // Reset: line high, not ready.
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_line", {31'd0, txd}, 32'd1);
            chk("rst_ready", {31'd0, axis.tready}, 32'd0);
        end
        rst = 1'b0;
        chk("rel_ready0", {31'd0, axis.tready}, 32'd0);
        step();
        chk("rel_ready1", {31'd0, axis.tready}, 32'd1);
        chk("rel_line", {31'd0, txd}, 32'd1);

        // Single byte 0xA5, cycle exact.
        send_byte(8'hA5, 1'b0, h);
        check_frame(8'hA5, "a5");
        chk("a5_ready_after", {31'd0, axis.tready}, 32'd1);

        // Back-to-back with tvalid held high.
        seq[0] = 8'h00;
        seq[1] = 8'hFF;
        seq[2] = 8'h55;
        rx_q.delete();
        rx_en = 1'b1;
        axis.tvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            axis.tdata = seq[k];
            wait_ready();
            hs[k] = cyc;
            step();
        end
        axis.tvalid = 1'b0;
        chk("b2b_gap01", hs[1] - hs[0], 32'd161);
        chk("b2b_gap12", hs[2] - hs[1], 32'd161);
        repeat (180) step();
        rx_en = 1'b0;
        chk("b2b_count", rx_q.size(), 32'd3);
        for (int k = 0; k < 3; k++)
            chk("b2b_byte", (k < rx_q.size()) ? {24'd0, rx_q[k]} : 32'hFFFF_FFFF, {24'd0, seq[k]});
        repeat (20) step();

        // Reset in the middle of DATA for 0x3C (bit 1 = 0 at N+40).
        send_byte(8'h3C, 1'b0, h);
        repeat (39) step();
        chk("mid_line_pre", {31'd0, txd}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_line", {31'd0, txd}, 32'd1);
        chk("mid_rst_ready", {31'd0, axis.tready}, 32'd0);
        step();
        chk("mid_ready_back", {31'd0, axis.tready}, 32'd1);
        send_byte(8'h81, 1'b0, h);
        check_frame(8'h81, "x81");
        chk("x81_ready_after", {31'd0, axis.tready}, 32'd1);

        // "OK" with tlast on 'K'.
        rx_q.delete();
        rx_en = 1'b1;
        send_byte(8'h4F, 1'b0, h);
        send_byte(8'h4B, 1'b1, hk);
        rdy_cyc = 0;
        for (int n = 0; n < 700; n++) begin
            if (axis.tready === 1'b1) begin
                rdy_cyc = cyc;
                break;
            end
            step();
        end
`ifdef STREAM_UART_EOL_EN
        chk("ok_ready_delay", rdy_cyc - hk, 32'd481);
        exp_ok = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
`else
        chk("ok_ready_delay", rdy_cyc - hk, 32'd161);
        exp_ok = '{8'h4F, 8'h4B};
`endif
        repeat (500) step();
        rx_en = 1'b0;
        chk("ok_count", rx_q.size(), exp_ok.size());
        for (int k = 0; k < exp_ok.size(); k++)
            chk("ok_byte", (k < rx_q.size()) ? {24'd0, rx_q[k]} : 32'hFFFF_FFFF,
                {24'd0, exp_ok[k]});

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
